smi_pixel_rx: RTL and testbench
===============================

Name: smi_pixel_rx

Overview:
Downstream consumer of the SMI byte interface. It takes bytes written by the Pi, parses a framed pixel protocol, and issues 24-bit RGB writes to the LED framebuffer. On each Pi read strobe it answers with a status byte, and it signals frame commits to the LED output stage.

Parameters:
ADDR_W, 10, framebuffer pixel address width; addresses wrap modulo 2^ADDR_W
SYNC, 8'hA5, packet start byte
TIMEOUT_W, 16, width of the inter-byte timeout counter; a packet aborts after 2^TIMEOUT_W-1 idle cycles

Ports:
clk  in  1  system clock (64 MHz PLL output)
reset  in  1  asynchronous, active-high reset
smi_in  in  8  byte written by the Pi; valid while write is high
write  in  1  one-cycle strobe: Pi wrote smi_in
read  in  1  one-cycle strobe: Pi requests a byte
smi_out  out  8  status byte returned to the Pi
fb_addr  out  ADDR_W  framebuffer pixel address
fb_data  out  24  pixel {R,G,B}
fb_we  out  1  one-cycle framebuffer write enable
frame_done  out  1  one-cycle commit pulse
err_count  out  8  saturating protocol-error counter

Behaviour:
- Reset is asynchronous and active-high. While reset is high: all outputs are 0 and the state is IDLE.
- All logic is clocked on posedge clk. Only cycles with write=1 advance the parser.
- Packet format: SYNC, CMD, ADDR_HI, ADDR_LO, COUNT, then COUNT pixels × (R, G, B). COUNT=0 means 256 pixels.
- CMD 8'h01: pixel write, the full packet above.
- CMD 8'h02: commit, ends after the CMD byte with no address or count bytes.
- States:
  - IDLE: SYNC byte -> CMD. Any other byte is ignored; no error.
  - CMD: 01 -> AH. 02 -> IDLE with frame_done=1 the next cycle. Any other value -> IDLE, err_count+1.
  - AH -> AL -> CNT. Address = {AH, AL}, truncated to the low ADDR_W bits.
  - CNT -> R -> G -> B -> back to R while pixels remain, else IDLE.
- Pixel write: the B byte accepted at cycle N gives fb_we=1 at N+1, with fb_data={R,G,B} and fb_addr = current pixel address. The address then increments for the next pixel and wraps from 2^ADDR_W-1 to 0.
- fb_addr and fb_data hold their values between writes; fb_we is 0 otherwise.
- Timeout: an idle counter clears on every write strobe and increments in any non-IDLE state. At all-ones it forces IDLE and err_count+1. A write strobe in the same cycle wins: the byte is consumed and no timeout occurs.
- err_count saturates at 8'hFF. If two error events fall in one cycle, it increments by 1 only.
- Read: on read=1, smi_out is loaded the next cycle with {state!=IDLE, err_count[6:0] saturated at 7'h7F}. smi_out holds until the next read.
- If read and write occur in the same cycle, both are serviced. The status reflects the state before the byte is consumed.
- A mid-packet reset discards the partial packet. No fb_we or frame_done is emitted for it.
- A SYNC value arriving mid-packet is treated as data, not as a resync.

Test Plan:
- Reset, then write A5 01 00 05 02 11 22 33 44 55 66 -> two fb_we pulses: addr 5 data 112233, then addr 6 data 445566. Each pulse is 1 cycle after its B byte strobe; state returns to IDLE.
- A5 01 03 FF 02 + 6 bytes with ADDR_W=10 -> writes at 1023 then 0 (wrap). Address 0x3FF is the truncated 0x03FF.
- A5 02 -> frame_done=1 for exactly 1 cycle; no fb_we. Then A5 07 -> err_count=1 and state IDLE.
- A5 01 00 00 (then stall 2^16 cycles) -> err_count increments once and state is IDLE. The following A5 02 commits normally.
- read strobe mid-packet after 3 errors -> next-cycle smi_out=8'h83. read after 200 errors -> smi_out=8'h7F and err_count=200.
- Assert reset after the G byte of a pixel -> no fb_we. After release, a fresh packet to addr 0 writes correctly with COUNT=00 producing 256 writes.

Source files
------------

// File: rtl/smi_pixel_rx.sv
// Parses framed pixel/commit packets from the Pi SMI byte stream into framebuffer
// writes and commit pulses, and answers read strobes with a status byte.
module smi_pixel_rx #(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] SYNC      = 8'hA5,
  parameter int         TIMEOUT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        smi_in,
  input  logic              write,
  input  logic              read,
  output logic [7:0]        smi_out,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [23:0]       fb_data,
  output logic              fb_we,
  output logic              frame_done,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_AH, S_AL, S_CNT, S_R, S_G, S_B} state_t;

  localparam logic [ADDR_W-1:0]    ADDR_ONE = ADDR_W'(1);
  localparam logic [TIMEOUT_W-1:0] TMO_ONE  = TIMEOUT_W'(1);

  state_t               state;
  logic [7:0]           addr_hi;
  logic [7:0]           red;
  logic [7:0]           green;
  logic [8:0]           remain;
  logic [ADDR_W-1:0]    pix_addr;
  logic [TIMEOUT_W-1:0] idle_cnt;
  logic [15:0]          full_addr;
  logic                 cmd_err;
  logic                 tmo;

  assign full_addr = {addr_hi, smi_in};
  assign cmd_err   = write && (state == S_CMD) && (smi_in != 8'h01) && (smi_in != 8'h02);
  // A write in the same cycle as counter expiry keeps the packet alive.
  assign tmo       = !write && (state != S_IDLE) && (&idle_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      addr_hi    <= 8'h00;
      red        <= 8'h00;
      green      <= 8'h00;
      remain     <= 9'd0;
      pix_addr   <= '0;
      idle_cnt   <= '0;
      smi_out    <= 8'h00;
      fb_addr    <= '0;
      fb_data    <= 24'h0;
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      err_count  <= 8'h00;
    end else begin
      fb_we      <= 1'b0;
      frame_done <= 1'b0;

      if (read)
        smi_out <= {state != S_IDLE, err_count[7] ? 7'h7F : err_count[6:0]};

      if ((cmd_err || tmo) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;

      if (write || state == S_IDLE)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + TMO_ONE;

      if (tmo) begin
        state <= S_IDLE;
      end else if (write) begin
        case (state)
          S_IDLE: if (smi_in == SYNC) state <= S_CMD;
          S_CMD: begin
            case (smi_in)
              8'h01: state <= S_AH;
              8'h02: begin
                state      <= S_IDLE;
                frame_done <= 1'b1;
              end
              default: state <= S_IDLE;
            endcase
          end
          S_AH: begin
            addr_hi <= smi_in;
            state   <= S_AL;
          end
          S_AL: begin
            pix_addr <= full_addr[ADDR_W-1:0];
            state    <= S_CNT;
          end
          S_CNT: begin
            remain <= (smi_in == 8'h00) ? 9'd256 : {1'b0, smi_in};
            state  <= S_R;
          end
          S_R: begin
            red   <= smi_in;
            state <= S_G;
          end
          S_G: begin
            green <= smi_in;
            state <= S_B;
          end
          S_B: begin
            fb_we    <= 1'b1;
            fb_addr  <= pix_addr;
            fb_data  <= {red, green, smi_in};
            pix_addr <= pix_addr + ADDR_ONE;
            remain   <= remain - 9'd1;
            state    <= (remain == 9'd1) ? S_IDLE : S_R;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_smi_pixel_rx.sv
// Bench for smi_pixel_rx: vector table, hand sequences for timeout/status/reset,
// and randomized packet streams scored against a packet-level reference parser.
module tb_smi_pixel_rx;
  localparam int ADDR_W = 10;
  typedef logic [ADDR_W+23:0] wr_t;

  typedef struct {
    logic [95:0] seq;
    int          n;
    int          nwe;
    wr_t         first;
    wr_t         last;
    int          nfd;
    logic [7:0]  err;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        smi_in;
  logic              write;
  logic              read;
  logic [7:0]        smi_out;
  logic [ADDR_W-1:0] fb_addr;
  logic [23:0]       fb_data;
  logic              fb_we;
  logic              frame_done;
  logic [7:0]        err_count;

  int checks = 0;
  int failures = 0;
  wr_t obs[$];
  int fd_seen = 0;

  logic [7:0] stream[$];
  wr_t        expw[$];
  int         efd, eerr;
  vec_t       vt[6];

  always #5 clk = ~clk;

  smi_pixel_rx #(.ADDR_W(ADDR_W), .SYNC(8'hA5), .TIMEOUT_W(16)) dut (
    .clk(clk), .reset(reset), .smi_in(smi_in), .write(write), .read(read),
    .smi_out(smi_out), .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .frame_done(frame_done), .err_count(err_count)
  );

  always @(negedge clk) begin
    if (fb_we) obs.push_back({fb_addr, fb_data});
    if (frame_done) fd_seen++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All stimulus tasks start and end just after a falling edge.
  task automatic wr(input logic [7:0] b);
    smi_in = b; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic rd();
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic rw(input logic [7:0] b);
    smi_in = b; write = 1'b1; read = 1'b1;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
  endtask

  task automatic send(input bit gaps);
    foreach (stream[k]) begin
      wr(stream[k]);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // Packet-level reference: walks the byte list packet by packet.
  task automatic model();
    int i, npx;
    logic [7:0] cmd;
    logic [15:0] a;
    expw.delete(); efd = 0; eerr = 0; i = 0;
    while (i < stream.size()) begin
      if (stream[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 1 >= stream.size()) break;
      cmd = stream[i+1];
      i += 2;
      if (cmd == 8'h02) efd++;
      else if (cmd != 8'h01) eerr++;
      else begin
        if (i + 3 > stream.size()) break;
        a = {stream[i], stream[i+1]};
        npx = (stream[i+2] == 8'h00) ? 256 : int'(stream[i+2]);
        i += 3;
        for (int p = 0; p < npx && i + 3 <= stream.size(); p++) begin
          expw.push_back({ADDR_W'((int'(a) + p) % (1 << ADDR_W)), stream[i], stream[i+1], stream[i+2]});
          i += 3;
        end
      end
    end
  endtask

  task automatic gen(input int npkt);
    logic [7:0] b;
    int c;
    stream.delete();
    for (int k = 0; k < npkt; k++) begin
      case ($urandom_range(0, 3))
        0: begin
          do b = 8'($urandom); while (b == 8'hA5);
          stream.push_back(b);
        end
        1: begin stream.push_back(8'hA5); stream.push_back(8'h02); end
        2: begin
          do b = 8'($urandom); while (b == 8'h01 || b == 8'h02);
          stream.push_back(8'hA5); stream.push_back(b);
        end
        default: begin
          c = $urandom_range(1, 4);
          stream.push_back(8'hA5); stream.push_back(8'h01);
          stream.push_back(8'($urandom)); stream.push_back(8'($urandom));
          stream.push_back(8'(c));
          for (int j = 0; j < 3 * c; j++) stream.push_back(8'($urandom));
        end
      endcase
    end
  endtask

  task automatic cmp_writes(input int base);
    int n;
    n = obs.size() - base;
    chk("write_count", 64'(n), 64'(expw.size()));
    for (int k = 0; k < n && k < expw.size(); k++)
      chk("write_entry", 64'(obs[base+k]), 64'(expw[k]));
  endtask

  initial begin
    int base, fdb, n;
    logic [7:0] b;
    logic [95:0] sq;

    vt[0] = '{96'hA5_01_00_05_02_11_22_33_44_55_66_00, 11, 2, {10'd5, 24'h112233}, {10'd6, 24'h445566}, 0, 8'd0};
    vt[1] = '{96'hA5_01_03_FF_02_AA_BB_CC_DD_EE_FF_00, 11, 2, {10'h3FF, 24'hAABBCC}, {10'h000, 24'hDDEEFF}, 0, 8'd0};
    vt[2] = '{96'hA5_02_00_00_00_00_00_00_00_00_00_00, 2, 0, '0, '0, 1, 8'd0};
    vt[3] = '{96'hA5_07_00_00_00_00_00_00_00_00_00_00, 2, 0, '0, '0, 0, 8'd1};
    vt[4] = '{96'h00_13_A5_01_00_10_01_A5_A5_A5_00_00, 10, 1, {10'h010, 24'hA5A5A5}, {10'h010, 24'hA5A5A5}, 0, 8'd1};
    vt[5] = '{96'hA5_09_00_00_00_00_00_00_00_00_00_00, 2, 0, '0, '0, 0, 8'd2};

    reset = 1'b1; write = 1'b0; read = 1'b0; smi_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_smi_out", 64'(smi_out), 64'h0);
    chk("rst_fb_we", 64'(fb_we), 64'h0);
    chk("rst_fb_addr", 64'(fb_addr), 64'h0);
    chk("rst_fb_data", 64'(fb_data), 64'h0);
    chk("rst_frame_done", 64'(frame_done), 64'h0);
    chk("rst_err", 64'(err_count), 64'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      base = obs.size(); fdb = fd_seen;
      sq = vt[r].seq;
      for (int k = 0; k < vt[r].n; k++) wr(sq[95-8*k -: 8]);
      repeat (3) @(negedge clk);
      n = obs.size() - base;
      chk("vec_nwe", 64'(n), 64'(vt[r].nwe));
      if (vt[r].nwe > 0 && n == vt[r].nwe) begin
        chk("vec_first", 64'(obs[base]), 64'(vt[r].first));
        chk("vec_last", 64'(obs[base+n-1]), 64'(vt[r].last));
      end
      chk("vec_frame_done", 64'(fd_seen - fdb), 64'(vt[r].nfd));
      chk("vec_err", 64'(err_count), 64'(vt[r].err));
      rd();
      chk("vec_status", 64'(smi_out), 64'({1'b0, vt[r].err[6:0]}));
    end

    // fb_we exactly one cycle after the B strobe; data holds afterwards.
    stream = '{8'hA5, 8'h01, 8'h00, 8'h20, 8'h01, 8'h11, 8'h22};
    send(1'b0);
    wr(8'h33);
    chk("lat_we", 64'(fb_we), 64'h1);
    chk("lat_addr", 64'(fb_addr), 64'h20);
    chk("lat_data", 64'(fb_data), 64'h112233);
    @(negedge clk);
    chk("lat_we_low", 64'(fb_we), 64'h0);
    chk("lat_data_hold", 64'(fb_data), 64'h112233);

    // Inter-byte timeout fires after exactly 2^16 stalled cycles.
    stream = '{8'hA5, 8'h01, 8'h00, 8'h00};
    send(1'b0);
    repeat (65535) @(negedge clk);
    chk("tmo_not_yet", 64'(err_count), 64'd2);
    @(negedge clk);
    chk("tmo_err", 64'(err_count), 64'd3);
    rd();
    chk("tmo_idle_status", 64'(smi_out), 64'h03);
    base = obs.size(); fdb = fd_seen;
    wr(8'hA5); wr(8'h02);
    repeat (2) @(negedge clk);
    chk("tmo_commit", 64'(fd_seen - fdb), 64'd1);
    chk("tmo_commit_nowe", 64'(obs.size() - base), 64'd0);

    wr(8'hA5); wr(8'h01);
    rd();
    chk("status_busy", 64'(smi_out), 64'h83);
    stream = '{8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
    send(1'b0);
    rw(8'hA5);
    chk("status_rw_same_cycle", 64'(smi_out), 64'h03);
    wr(8'h07);
    chk("err_after_rw", 64'(err_count), 64'd4);
    for (int k = 0; k < 196; k++) begin wr(8'hA5); wr(8'h07); end
    rd();
    chk("status_sat7f", 64'(smi_out), 64'h7F);
    chk("err_200", 64'(err_count), 64'd200);
    for (int k = 0; k < 54; k++) begin wr(8'hA5); wr(8'h07); end
    chk("err_254", 64'(err_count), 64'hFE);
    wr(8'hA5); wr(8'h07);
    chk("err_255", 64'(err_count), 64'hFF);
    wr(8'hA5); wr(8'h07);
    chk("err_sat", 64'(err_count), 64'hFF);

    // Mid-pixel reset discards the partial packet.
    base = obs.size(); fdb = fd_seen;
    stream = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22};
    send(1'b0);
    #1 reset = 1'b1;
    #1;
    chk("arst_err", 64'(err_count), 64'h0);
    chk("arst_smi_out", 64'(smi_out), 64'h0);
    chk("arst_fb_data", 64'(fb_data), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_we", 64'(obs.size() - base), 64'd0);
    chk("arst_no_fd", 64'(fd_seen - fdb), 64'd0);
    rd();
    chk("arst_status", 64'(smi_out), 64'h00);

    // COUNT=0 means 256 pixels.
    stream = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k < 768; k++) stream.push_back(8'($urandom));
    model();
    base = obs.size();
    send(1'b0);
    repeat (3) @(negedge clk);
    chk("cnt256_len", 64'(expw.size()), 64'd256);
    cmp_writes(base);

    // Randomized packet streams with random inter-byte gaps.
    gen(40);
    model();
    base = obs.size(); fdb = fd_seen;
    send(1'b1);
    repeat (3) @(negedge clk);
    cmp_writes(base);
    chk("rand_frame_done", 64'(fd_seen - fdb), 64'(efd));
    chk("rand_err", 64'(err_count), 64'(eerr > 255 ? 255 : eerr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
